// File: rtl/ex_stage.sv
// Execute stage: registers the decode bus, evaluates the ALU, drives the
// data-SRAM request, and owns HI/LO with a multiplier and a serial divider.
//
// Divider states
//   state     | meaning
//   DIV_IDLE  | no divide in flight; a DIV/DIVU with nonzero divisor starts one
//   DIV_BUSY  | one restoring shift/subtract step per cycle, 32 steps total
//   DIV_DONE  | quotient/remainder ready; committed to LO/HI when EX advances
module ex_stage (
   input  logic         clk,
   input  logic         rst,
   input  logic [5:0]   stall,
   output logic         stallreq_for_ex,
   input  logic [158:0] id_to_ex_bus,
   output logic [75:0]  ex_to_mem_bus,
   output logic [37:0]  ex_to_rf_bus,
   output logic         data_sram_en,
   output logic [3:0]   data_sram_wen,
   output logic [31:0]  data_sram_addr,
   output logic [31:0]  data_sram_wdata
);

   localparam int ID_TO_EX_WD = 159;

   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MTLO  = 6'b010011;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   logic [ID_TO_EX_WD-1:0] id_q, id_d;

   logic [31:0] pc, inst, rdata1, rdata2;
   logic [11:0] alu_op;
   logic [2:0]  sel_alu_src1;
   logic [3:0]  sel_alu_src2;
   logic        data_ram_en, rf_we, sel_rf_res;
   logic [3:0]  data_ram_wen;
   logic [4:0]  rf_waddr;

   assign pc           = id_q[158:127];
   assign inst         = id_q[126:95];
   assign alu_op       = id_q[94:83];
   assign sel_alu_src1 = id_q[82:80];
   assign sel_alu_src2 = id_q[79:76];
   assign data_ram_en  = id_q[75];
   assign data_ram_wen = id_q[74:71];
   assign rf_we        = id_q[70];
   assign rf_waddr     = id_q[69:65];
   assign sel_rf_res   = id_q[64];
   assign rdata1       = id_q[63:32];
   assign rdata2       = id_q[31:0];

   logic        op_special;
   logic [5:0]  func;
   logic        is_mult, is_multu, is_div, is_divu, is_mfhi, is_mthi, is_mflo, is_mtlo;

   assign op_special = (inst[31:26] == 6'b000000);
   assign func       = inst[5:0];
   assign is_mult    = op_special && (func == FN_MULT);
   assign is_multu   = op_special && (func == FN_MULTU);
   assign is_div     = op_special && (func == FN_DIV);
   assign is_divu    = op_special && (func == FN_DIVU);
   assign is_mfhi    = op_special && (func == FN_MFHI);
   assign is_mthi    = op_special && (func == FN_MTHI);
   assign is_mflo    = op_special && (func == FN_MFLO);
   assign is_mtlo    = op_special && (func == FN_MTLO);

   // input register: bubble when EX stops but MEM runs, load when EX runs
   always_comb begin
      id_d = id_q;
      if (stall[2] && !stall[3]) begin
         id_d = '0;
      end else if (!stall[2]) begin
         id_d = id_to_ex_bus;
      end
   end

   // operand selection; each select is one-hot, zero select gives zero
   logic [31:0] src1, src2;
   always_comb begin
      src1 = '0;
      src2 = '0;
      if (sel_alu_src1[0]) src1 = src1 | rdata1;
      if (sel_alu_src1[1]) src1 = src1 | pc;
      if (sel_alu_src1[2]) src1 = src1 | {27'b0, inst[10:6]};
      if (sel_alu_src2[0]) src2 = src2 | rdata2;
      if (sel_alu_src2[1]) src2 = src2 | {{16{inst[15]}}, inst[15:0]};
      if (sel_alu_src2[2]) src2 = src2 | 32'd8;
      if (sel_alu_src2[3]) src2 = src2 | {16'b0, inst[15:0]};
   end

   // ALU: OR of the gated per-op results
   logic [31:0] alu_result;
   logic [31:0] sra_res;
   assign sra_res = $signed(src2) >>> src1[4:0];
   always_comb begin
      alu_result = '0;
      if (alu_op[11]) alu_result = alu_result | (src1 + src2);
      if (alu_op[10]) alu_result = alu_result | (src1 - src2);
      if (alu_op[9])  alu_result = alu_result | {31'b0, ($signed(src1) < $signed(src2))};
      if (alu_op[8])  alu_result = alu_result | {31'b0, (src1 < src2)};
      if (alu_op[7])  alu_result = alu_result | (src1 & src2);
      if (alu_op[6])  alu_result = alu_result | ~(src1 | src2);
      if (alu_op[5])  alu_result = alu_result | (src1 | src2);
      if (alu_op[4])  alu_result = alu_result | (src1 ^ src2);
      if (alu_op[3])  alu_result = alu_result | (src2 << src1[4:0]);
      if (alu_op[2])  alu_result = alu_result | (src2 >> src1[4:0]);
      if (alu_op[1])  alu_result = alu_result | sra_res;
      if (alu_op[0])  alu_result = alu_result | {src2[15:0], 16'b0};
   end

   logic [63:0] prod_s, prod_u;
   assign prod_s = $signed({{32{rdata1[31]}}, rdata1}) * $signed({{32{rdata2[31]}}, rdata2});
   assign prod_u = {32'b0, rdata1} * {32'b0, rdata2};

   div_state_t  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
   logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic        div_start;

   logic [31:0] dvnd_mag, dvsr_mag;
   assign dvnd_mag = (is_div && rdata1[31]) ? (~rdata1 + 32'd1) : rdata1;
   assign dvsr_mag = (is_div && rdata2[31]) ? (~rdata2 + 32'd1) : rdata2;

   logic [32:0] trial, diff;
   assign trial = {rem_q, quo_q[31]};
   assign diff  = trial - {1'b0, dvsr_q};

   // divider next-state, datapath step and stall request
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvsr_d    = dvsr_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      div_start = 1'b0;
      case (state_q)
         DIV_IDLE: begin
            if ((is_div || is_divu) && (rdata2 != 32'd0)) begin
               div_start = 1'b1;
               state_d   = DIV_BUSY;
               quo_d     = dvnd_mag;
               dvsr_d    = dvsr_mag;
               rem_d     = '0;
               cnt_d     = '0;
               q_neg_d   = is_div && (rdata1[31] ^ rdata2[31]);
               r_neg_d   = is_div && rdata1[31];
            end
         end
         DIV_BUSY: begin
            if (!diff[32]) begin
               rem_d = diff[31:0];
               quo_d = {quo_q[30:0], 1'b1};
            end else begin
               rem_d = trial[31:0];
               quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = DIV_DONE;
         end
         DIV_DONE: begin
            if (!stall[2]) state_d = DIV_IDLE;
         end
         default: state_d = DIV_IDLE;
      endcase
   end

   assign stallreq_for_ex = div_start || (state_q == DIV_BUSY);

   // HI/LO writes commit only on the edge where the instruction leaves EX
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (!stall[2]) begin
         if (state_q == DIV_DONE) begin
            lo_d = q_neg_q ? (~quo_q + 32'd1) : quo_q;
            hi_d = r_neg_q ? (~rem_q + 32'd1) : rem_q;
         end else if (is_mult) begin
            hi_d = prod_s[63:32];
            lo_d = prod_s[31:0];
         end else if (is_multu) begin
            hi_d = prod_u[63:32];
            lo_d = prod_u[31:0];
         end else if (is_mthi) begin
            hi_d = rdata1;
         end else if (is_mtlo) begin
            lo_d = rdata1;
         end
      end
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         id_q    <= '0;
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         id_q    <= id_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvsr_q  <= dvsr_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   logic [31:0] ex_result;
   logic        rf_we_o;
   logic [4:0]  rf_waddr_o;

   // MFHI/MFLO source HI/LO and always write rd
   always_comb begin
      ex_result  = alu_result;
      rf_we_o    = rf_we;
      rf_waddr_o = rf_waddr;
      if (is_mfhi || is_mflo) begin
         ex_result  = is_mfhi ? hi_q : lo_q;
         rf_we_o    = 1'b1;
         rf_waddr_o = inst[15:11];
      end
   end

   assign ex_to_rf_bus    = {rf_we_o, rf_waddr_o, ex_result};
   assign ex_to_mem_bus   = {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we_o, rf_waddr_o, ex_result};
   assign data_sram_en    = data_ram_en;
   assign data_sram_wen   = data_ram_wen;
   assign data_sram_addr  = alu_result;
   assign data_sram_wdata = rdata2;

   logic unused_bits;
   assign unused_bits = ^{stall[5:4], stall[1:0], inst[25:16], trial[32]};

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against a behavioural ISA-level model.
module tb_ex_stage;

   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MTLO  = 6'b010011;

   logic         clk = 1'b0;
   logic         rst;
   logic [5:0]   stall;
   logic         stallreq_for_ex;
   logic [158:0] id_to_ex_bus;
   logic [75:0]  ex_to_mem_bus;
   logic [37:0]  ex_to_rf_bus;
   logic         data_sram_en;
   logic [3:0]   data_sram_wen;
   logic [31:0]  data_sram_addr;
   logic [31:0]  data_sram_wdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_hi, m_lo;
   logic        pend_whi, pend_wlo;
   logic [31:0] pend_hi, pend_lo;

   ex_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .stallreq_for_ex (stallreq_for_ex),
      .id_to_ex_bus    (id_to_ex_bus),
      .ex_to_mem_bus   (ex_to_mem_bus),
      .ex_to_rf_bus    (ex_to_rf_bus),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [158:0] make_bus(
      input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
      input logic [2:0] s1, input logic [3:0] s2, input logic ram_en,
      input logic [3:0] ram_wen, input logic we, input logic [4:0] wa,
      input logic selres, input logic [31:0] r1, input logic [31:0] r2);
      return {pc, inst, op, s1, s2, ram_en, ram_wen, we, wa, selres, r1, r2};
   endfunction

   function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd);
      return {6'b0, 10'b0, rd, 5'b0, fn};
   endfunction

   function automatic logic [31:0] ref_alu(input logic [158:0] b);
      logic [31:0] pc, inst, r1, r2, a, c;
      logic signed [31:0] cs;
      pc = b[158:127]; inst = b[126:95]; r1 = b[63:32]; r2 = b[31:0];
      case (b[82:80])
         3'b001:  a = r1;
         3'b010:  a = pc;
         3'b100:  a = {27'b0, inst[10:6]};
         default: a = 32'd0;
      endcase
      case (b[79:76])
         4'b0001: c = r2;
         4'b0010: c = {{16{inst[15]}}, inst[15:0]};
         4'b0100: c = 32'd8;
         4'b1000: c = {16'b0, inst[15:0]};
         default: c = 32'd0;
      endcase
      cs = c;
      case (b[94:83])
         12'h800: return a + c;
         12'h400: return a - c;
         12'h200: return ($signed(a) < $signed(c)) ? 32'd1 : 32'd0;
         12'h100: return (a < c) ? 32'd1 : 32'd0;
         12'h080: return a & c;
         12'h040: return ~(a | c);
         12'h020: return a | c;
         12'h010: return a ^ c;
         12'h008: return c << a[4:0];
         12'h004: return c >> a[4:0];
         12'h002: return 32'(cs >>> a[4:0]);
         12'h001: return {c[15:0], 16'b0};
         default: return 32'd0;
      endcase
   endfunction

   task automatic apply_pending();
      if (pend_whi) m_hi = pend_hi;
      if (pend_wlo) m_lo = pend_lo;
      pend_whi = 1'b0;
      pend_wlo = 1'b0;
   endtask

   task automatic discard_pending();
      pend_whi = 1'b0;
      pend_wlo = 1'b0;
   endtask

   // Load one instruction into EX, check outputs, model its HI/LO effect,
   // and if it is a divide, run the stall loop until the result is ready.
   task automatic issue(input logic [158:0] b, input string tag,
                        output logic [37:0] exp_rf, output logic was_div);
      logic [31:0] inst, r1, r2, res;
      logic [5:0]  fn;
      logic        sp, we;
      logic [4:0]  wa;
      longint      p, q, r;
      logic [63:0] pv, qv, rv;
      int          cnt, exp_cnt;
      apply_pending();
      id_to_ex_bus = b;
      stall = 6'b0;
      @(posedge clk); #1;
      inst = b[126:95]; r1 = b[63:32]; r2 = b[31:0]; fn = inst[5:0];
      sp = (inst[31:26] == 6'b0);
      res = ref_alu(b); we = b[70]; wa = b[69:65];
      if (sp && (fn == FN_MFHI || fn == FN_MFLO)) begin
         res = (fn == FN_MFHI) ? m_hi : m_lo;
         we = 1'b1;
         wa = inst[15:11];
      end
      exp_rf = {we, wa, res};
      check({tag, "_rf"}, ex_to_rf_bus, exp_rf);
      check({tag, "_mem"}, ex_to_mem_bus, {b[158:127], b[75], b[74:71], b[64], we, wa, res});
      check({tag, "_sram"}, {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
            {b[75], b[74:71], ref_alu(b), r2});
      exp_cnt = 0;
      was_div = 1'b0;
      if (sp) begin
         case (fn)
            FN_MULT: begin
               p = longint'($signed(r1)) * longint'($signed(r2));
               pv = p;
               pend_whi = 1'b1; pend_hi = pv[63:32];
               pend_wlo = 1'b1; pend_lo = pv[31:0];
            end
            FN_MULTU: begin
               pv = {32'b0, r1} * {32'b0, r2};
               pend_whi = 1'b1; pend_hi = pv[63:32];
               pend_wlo = 1'b1; pend_lo = pv[31:0];
            end
            FN_MTHI: begin pend_whi = 1'b1; pend_hi = r1; end
            FN_MTLO: begin pend_wlo = 1'b1; pend_lo = r1; end
            FN_DIV, FN_DIVU: begin
               if (r2 != 32'd0) begin
                  if (fn == FN_DIV) begin
                     q = longint'($signed(r1)) / longint'($signed(r2));
                     r = longint'($signed(r1)) % longint'($signed(r2));
                  end else begin
                     q = longint'({32'b0, r1}) / longint'({32'b0, r2});
                     r = longint'({32'b0, r1}) % longint'({32'b0, r2});
                  end
                  qv = q; rv = r;
                  pend_wlo = 1'b1; pend_lo = qv[31:0];
                  pend_whi = 1'b1; pend_hi = rv[31:0];
                  exp_cnt = 33;
                  was_div = 1'b1;
               end
            end
            default: ;
         endcase
      end
      cnt = 0;
      while (stallreq_for_ex && cnt < 40) begin
         cnt++;
         stall = 6'b001111;
         @(posedge clk); #1;
      end
      stall = 6'b0;
      check({tag, "_stallcyc"}, cnt, exp_cnt);
   endtask

   task automatic bubble(input string tag);
      stall = 6'b000100;
      @(posedge clk); #1;
      discard_pending();
      check({tag, "_bub_rf"}, ex_to_rf_bus, 38'd0);
      check({tag, "_bub_mem"}, ex_to_mem_bus, 76'd0);
      check({tag, "_bub_sram"}, {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, 69'd0);
      stall = 6'b0;
   endtask

   logic [158:0] b;
   logic [37:0]  erf;
   logic         wdiv;
   logic [5:0]   hl_fn [8];

   initial begin
      hl_fn = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO};
      m_hi = 0; m_lo = 0;
      discard_pending();
      pend_hi = 0; pend_lo = 0;
      rst = 1'b0;
      stall = 6'b0;
      id_to_ex_bus = {159{1'b1}};
      repeat (3) @(posedge clk);
      #1;
      check("rst_rf", ex_to_rf_bus, 38'd0);
      check("rst_mem", ex_to_mem_bus, 76'd0);
      check("rst_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, 69'd0);
      check("rst_stallreq", stallreq_for_ex, 1'b0);
      rst = 1'b1;

      // directed ALU cases
      b = make_bus(32'h0040_0000, 32'h00A3_3821, 12'h800, 3'b001, 4'b0001, 0, 0, 1, 5'd7, 0, 32'd5, 32'd3);
      issue(b, "addu", erf, wdiv);
      check("addu_const", ex_to_rf_bus, {1'b1, 5'd7, 32'd8});
      b = make_bus(32'h0040_0004, 32'h00A3_3823, 12'h400, 3'b001, 4'b0001, 0, 0, 1, 5'd7, 0, 32'd5, 32'd3);
      issue(b, "subu", erf, wdiv);
      check("subu_const", ex_to_rf_bus, {1'b1, 5'd7, 32'd2});
      b = make_bus(32'h0040_0008, 32'h00A3_382A, 12'h200, 3'b001, 4'b0001, 0, 0, 1, 5'd7, 0, 32'hFFFF_FFFF, 32'd1);
      issue(b, "slt", erf, wdiv);
      check("slt_const", ex_to_rf_bus, {1'b1, 5'd7, 32'd1});
      b = make_bus(32'h0040_000C, 32'h00A3_382B, 12'h100, 3'b001, 4'b0001, 0, 0, 1, 5'd7, 0, 32'hFFFF_FFFF, 32'd1);
      issue(b, "sltu", erf, wdiv);
      check("sltu_const", ex_to_rf_bus, {1'b1, 5'd7, 32'd0});
      b = make_bus(32'h0040_0010, 32'h0C00_0000, 12'h800, 3'b010, 4'b0100, 0, 0, 1, 5'd31, 0, 32'd0, 32'd0);
      issue(b, "jal", erf, wdiv);
      check("jal_const", ex_to_rf_bus, {1'b1, 5'd31, 32'h0040_0018});

      // MULT then MFLO/MFHI back to back
      issue(make_bus(0, rtype(FN_MULT, 0), 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFD, 32'd7), "mult", erf, wdiv);
      issue(make_bus(0, rtype(FN_MFLO, 5'd2), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mflo_mult", erf, wdiv);
      check("mflo_mult_const", ex_to_rf_bus, {1'b1, 5'd2, 32'hFFFF_FFEB});
      issue(make_bus(0, rtype(FN_MFHI, 5'd3), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mfhi_mult", erf, wdiv);
      check("mfhi_mult_const", ex_to_rf_bus, {1'b1, 5'd3, 32'hFFFF_FFFF});

      // signed and unsigned divides
      issue(make_bus(0, rtype(FN_DIV, 0), 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFF9, 32'd2), "div", erf, wdiv);
      issue(make_bus(0, rtype(FN_MFLO, 5'd4), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mflo_div", erf, wdiv);
      check("mflo_div_const", ex_to_rf_bus, {1'b1, 5'd4, 32'hFFFF_FFFD});
      issue(make_bus(0, rtype(FN_MFHI, 5'd5), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mfhi_div", erf, wdiv);
      check("mfhi_div_const", ex_to_rf_bus, {1'b1, 5'd5, 32'hFFFF_FFFF});
      issue(make_bus(0, rtype(FN_DIVU, 0), 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'd16), "divu", erf, wdiv);
      issue(make_bus(0, rtype(FN_MFLO, 5'd4), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mflo_divu", erf, wdiv);
      check("mflo_divu_const", ex_to_rf_bus, {1'b1, 5'd4, 32'h0FFF_FFFF});
      issue(make_bus(0, rtype(FN_MFHI, 5'd5), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mfhi_divu", erf, wdiv);
      check("mfhi_divu_const", ex_to_rf_bus, {1'b1, 5'd5, 32'h0000_000F});

      // divide by zero leaves HI alone and never stalls
      issue(make_bus(0, rtype(FN_MTHI, 0), 0, 0, 0, 0, 0, 0, 0, 0, 32'h11, 0), "mthi", erf, wdiv);
      issue(make_bus(0, rtype(FN_DIVU, 0), 0, 0, 0, 0, 0, 0, 0, 0, 32'd99, 32'd0), "divz", erf, wdiv);
      issue(make_bus(0, rtype(FN_MFHI, 5'd6), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mfhi_divz", erf, wdiv);
      check("mfhi_divz_const", ex_to_rf_bus, {1'b1, 5'd6, 32'h11});

      // bubble after a normal instruction
      b = make_bus(32'h1234, 32'h2000_0000, 12'h800, 3'b001, 4'b0001, 1, 4'hF, 1, 5'd9, 1, 32'd1, 32'd2);
      issue(b, "pre_bub", erf, wdiv);
      bubble("dir");

      // reset in the middle of a divide
      apply_pending();
      id_to_ex_bus = make_bus(0, rtype(FN_DIV, 0), 0, 0, 0, 0, 0, 0, 0, 0, 32'd1000, 32'd7);
      stall = 6'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 11; k++) begin
         stall = 6'b001111;
         @(posedge clk); #1;
      end
      check("abort_busy", stallreq_for_ex, 1'b1);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      check("abort_stallreq", stallreq_for_ex, 1'b0);
      check("abort_rf", ex_to_rf_bus, 38'd0);
      m_hi = 0; m_lo = 0;
      discard_pending();
      stall = 6'b0;
      issue(make_bus(0, rtype(FN_MFLO, 5'd8), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mflo_abort", erf, wdiv);
      check("mflo_abort_const", ex_to_rf_bus, {1'b1, 5'd8, 32'd0});

      // randomized mix
      for (int n = 0; n < 150; n++) begin
         logic [31:0] inst, r1, r2;
         logic [11:0] op;
         logic [2:0]  s1;
         logic [3:0]  s2;
         int k;
         r1 = $urandom; r2 = $urandom;
         if ($urandom_range(0, 3) == 0) r1 = 32'($urandom_range(0, 40)) - 32'd20;
         if ($urandom_range(0, 3) == 0) r2 = 32'($urandom_range(0, 40)) - 32'd20;
         if ($urandom_range(0, 9) < 6) begin
            inst = $urandom;
            inst[31:26] = 6'($urandom_range(1, 63));
            k = $urandom_range(0, 12);
            op = (k == 12) ? 12'd0 : (12'd1 << k);
            k = $urandom_range(0, 3);
            s1 = (k == 3) ? 3'd0 : (3'd1 << k);
            k = $urandom_range(0, 4);
            s2 = (k == 4) ? 4'd0 : (4'd1 << k);
         end else begin
            inst = rtype(hl_fn[$urandom_range(0, 7)], 5'($urandom_range(0, 31)));
            op = 12'd0; s1 = 3'd0; s2 = 4'd0;
            if ($urandom_range(0, 4) == 0) r2 = 32'd0;
         end
         b = make_bus($urandom, inst, op, s1, s2, 1'($urandom), 4'($urandom), 1'($urandom),
                      5'($urandom), 1'($urandom), r1, r2);
         issue(b, "rnd", erf, wdiv);
         if (!wdiv) begin
            k = $urandom_range(0, 9);
            if (k == 0) begin
               bubble("rnd");
            end else if (k == 1) begin
               stall = 6'b001111;
               @(posedge clk); #1;
               check("rnd_hold", ex_to_rf_bus, erf);
               stall = 6'b0;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
